game_over_text_renderer: RTL

Pixel-stream reader for the 7-glyph "GAME OVER" font ROM (G, A, M, E, O, V, R; 16 rows × 8 bits each). It sits beside the VGA colour mapper: for each DrawX/DrawY it computes the ROM address, reads the glyph row, and returns a registered `text_on` pixel. A frame-driven sequencer reveals the nine characters of "GAME OVER" one at a time, then blinks the whole string while `game_over` is held.

---
 rtl/game_over_pkg.sv | 33 +++
 rtl/game_over_text_renderer_seq.sv | 98 +++++++++
 rtl/game_over_text_renderer.sv | 113 +++++++++++
 3 files changed

// File: rtl/game_over_pkg.sv
// Shared definitions for the "GAME OVER" text renderer: sequencer states,
// string length and the character-to-font-letter map.
package game_over_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REVEAL = 2'd1,
        ST_BLINK  = 2'd2
    } seq_state_e;

    localparam int TEXT_LEN = 9;

    // Letter code that has no glyph in the font ROM; never lights a pixel.
    localparam logic [2:0] LETTER_SPACE = 3'd7;

    // Character index 0..8 of "GAME OVER" -> ROM letter (G A M E O V R = 0..6).
    localparam logic [2:0] CHAR_LETTER [TEXT_LEN] = '{
        3'd0, 3'd1, 3'd2, 3'd3, LETTER_SPACE, 3'd4, 3'd5, 3'd3, 3'd6
    };

    // Character cells beyond the string (possible outside the box) read as SPACE.
    function automatic logic [2:0] char_to_letter(input logic [3:0] c);
        logic [2:0] letter;
        letter = LETTER_SPACE;
        for (int i = 0; i < TEXT_LEN; i++) begin
            if (c == 4'(i)) begin
                letter = CHAR_LETTER[i];
            end
        end
        return letter;
    endfunction

endpackage

// File: rtl/game_over_text_renderer_seq.sv
// Frame-driven reveal/blink sequencer for the "GAME OVER" string.
// frame_start is a single-cycle strobe with no backpressure: every cycle it is
// high counts as one frame; game_over is a level that gates the whole sequence.
module game_over_seq
    import game_over_pkg::*;
#(
    parameter int REVEAL_FRAMES = 8,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_start_i,
    input  logic       game_over_i,
    output logic [1:0] state_o,
    output logic [3:0] shown_o,
    output logic       vis_o,
    output logic       reveal_done_o
);

    localparam int CNT_MAX = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] REVEAL_LAST = CNT_W'(REVEAL_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       SHOWN_ALL   = 4'(TEXT_LEN);

    seq_state_e       state_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [3:0]       shown_q;
    logic             vis_q;
    logic             done_q;

    // Sequencer FSM; dropping game_over wins over everything, including a frame pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            shown_q     <= '0;
            vis_q       <= 1'b0;
            done_q      <= 1'b0;
        end else if (!game_over_i) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            shown_q     <= '0;
            vis_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Entry cycle: a coincident frame pulse is not counted.
                    state_q     <= ST_REVEAL;
                    frame_cnt_q <= '0;
                    shown_q     <= '0;
                    vis_q       <= 1'b0;
                    done_q      <= 1'b0;
                end
                ST_REVEAL: begin
                    if (frame_start_i) begin
                        if (frame_cnt_q == REVEAL_LAST) begin
                            frame_cnt_q <= '0;
                            if (shown_q == SHOWN_ALL - 4'd1) begin
                                // Last character revealed: go straight to the blink phase, visible.
                                state_q <= ST_BLINK;
                                shown_q <= SHOWN_ALL;
                                vis_q   <= 1'b1;
                                done_q  <= 1'b1;
                            end else begin
                                shown_q <= shown_q + 4'd1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_BLINK: begin
                    if (frame_start_i) begin
                        if (frame_cnt_q == BLINK_LAST) begin
                            frame_cnt_q <= '0;
                            vis_q       <= ~vis_q;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o       = state_q;
    assign shown_o       = shown_q;
    assign vis_o         = vis_q;
    assign reveal_done_o = done_q;

endmodule

// File: rtl/game_over_text_renderer.sv
// Pixel-stream front end for the "GAME OVER" font ROM: maps DrawX/DrawY into
// the text box, issues a registered ROM address and returns a registered
// text_on two cycles after the pixel coordinates.
module game_over_text_renderer
    import game_over_pkg::*;
#(
    parameter int X0            = 248,
    parameter int Y0            = 224,
    parameter int SCALE_LOG2    = 1,
    parameter int REVEAL_FRAMES = 8,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       game_over,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       text_on,
    output logic       reveal_done
);

    localparam logic [10:0] X0_W  = 11'(X0);
    localparam logic [10:0] Y0_W  = 11'(Y0);
    localparam logic [10:0] BOX_W = 11'((TEXT_LEN * 8) << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(16 << SCALE_LOG2);

    logic [1:0] seq_state;
    logic [3:0] shown;
    logic       vis;

    game_over_seq #(
        .REVEAL_FRAMES (REVEAL_FRAMES),
        .BLINK_FRAMES  (BLINK_FRAMES)
    ) u_seq (
        .clk_i         (Clk),
        .rst_ni        (Reset_n),
        .frame_start_i (frame_start),
        .game_over_i   (game_over),
        .state_o       (seq_state),
        .shown_o       (shown),
        .vis_o         (vis),
        .reveal_done_o (reveal_done)
    );

    logic [10:0] draw_x_w;
    logic [10:0] draw_y_w;
    logic [10:0] rel_x;
    logic [10:0] rel_y;
    logic [6:0]  gx;
    logic [3:0]  char_idx;
    logic [2:0]  col;
    logic [3:0]  row;
    logic [2:0]  letter;
    logic        in_box;
    logic        eligible;
    logic        not_space;

    // Geometry: the explicit >= compares stop pixels left/above the box from
    // wrapping around into small rel_x/rel_y values.
    always_comb begin
        draw_x_w  = {1'b0, DrawX};
        draw_y_w  = {1'b0, DrawY};
        rel_x     = draw_x_w - X0_W;
        rel_y     = draw_y_w - Y0_W;
        in_box    = (draw_x_w >= X0_W) && (rel_x < BOX_W) &&
                    (draw_y_w >= Y0_W) && (rel_y < BOX_H);
        gx        = 7'(rel_x >> SCALE_LOG2);
        char_idx  = gx[6:3];
        col       = gx[2:0];
        row       = 4'(rel_y >> SCALE_LOG2);
        letter    = char_to_letter(char_idx);
        not_space = (letter != LETTER_SPACE);
        eligible  = ((seq_state == ST_REVEAL) && (char_idx < shown)) ||
                    ((seq_state == ST_BLINK) && vis);
    end

    logic [6:0] rom_addr_q;
    logic [2:0] col_q;
    logic       in_box_q;
    logic       qual_q;
    logic       text_on_q;

    // Stage 1: ROM address plus the per-pixel qualifiers that travel with it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            col_q      <= '0;
            in_box_q   <= 1'b0;
            qual_q     <= 1'b0;
        end else begin
            rom_addr_q <= {letter, row};
            col_q      <= col;
            in_box_q   <= in_box;
            qual_q     <= eligible & not_space;
        end
    end

    // Stage 2: select the glyph bit (MSB is leftmost, so bit index is ~col).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            text_on_q <= 1'b0;
        end else begin
            text_on_q <= rom_data[~col_q] & in_box_q & qual_q;
        end
    end

    assign rom_addr = rom_addr_q;
    assign text_on  = text_on_q;

endmodule
